// File: rtl/mux_2to1_pkg.sv
// Shared constants for the 2:1 data selector: default sizes and select encoding.
package mux_2to1_pkg;
    localparam int   DEF_WIDTH = 1;
    localparam int   DEF_CNT_W = 8;
    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;

    function automatic logic sel_changed(input logic cur, input logic prev);
        return cur != prev;
    endfunction
endpackage

// File: rtl/mux_2to1_sat_counter.sv
// CNT_W-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = mux_2to1_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/mux_2to1.sv
// 2:1 selector with combinational and load-enabled registered outputs,
// plus a saturating count of select transitions for debug visibility.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_changes
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_prev_q, sel_prev_d;

    // Live through reset: no dependence on clk, rst_n or en.
    assign out = (sel == SEL_A) ? a : b;

    always_comb begin
        data_d     = en ? out : data_q;
        sel_prev_d = sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            sel_prev_q <= SEL_A;
        end else begin
            data_q     <= data_d;
            sel_prev_q <= sel_prev_d;
        end
    end

    assign out_q = data_q;

    // Only edge-sampled differences count, so a glitch between edges is invisible.
    sat_counter #(.CNT_W(CNT_W)) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel_changed(sel, sel_prev_q)),
        .cnt   (sel_changes)
    );
endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench: WIDTH=8/CNT_W=8 instance for the registered path and counter,
// WIDTH=1/CNT_W=2 instance for the exhaustive mux table and saturation.
module tb_mux_2to1;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;

    logic [7:0] a8, b8, out8, q8, cnt8;
    logic       sel8, en8;
    logic       a1, b1, sel1, en1, out1, q1;
    logic [1:0] cnt1;

    always #5 if (clk_en) clk = ~clk;

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .en(en8),
        .out(out8), .out_q(q8), .sel_changes(cnt8)
    );

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .en(en1),
        .out(out1), .out_q(q1), .sel_changes(cnt1)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic a;
        logic b;
        logic sel;
        logic exp;
    } vec_t;
    vec_t vt[8];

    int n_chk = 0;
    int n_pass = 0;

    task automatic sb_push(input string n, input logic [31:0] e);
        sb_t r;
        r.name = n;
        r.exp  = e;
        sbq.push_back(r);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t r;
        n_chk++;
        if (sbq.size() == 0) begin
            $display("FAIL sb_underflow: got %0h with nothing expected", act);
            return;
        end
        r = sbq.pop_front();
        if (act === r.exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", r.name, act, r.exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // {a, b, sel} = 0..7 with hand-derived expectations
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0; en8 = 1'b0;
        a1 = 1'b0;  b1 = 1'b0;  sel1 = 1'b0; en1 = 1'b0;
        #3;

        sb_push("rst_q8", 0);   sb_pop(32'(q8));
        sb_push("rst_cnt8", 0); sb_pop(32'(cnt8));
        sb_push("rst_q1", 0);   sb_pop(32'(q1));
        sb_push("rst_cnt1", 0); sb_pop(32'(cnt1));

        // Exhaustive mux table, no clock edges at all
        for (int i = 0; i < 8; i++) begin
            a1 = vt[i].a; b1 = vt[i].b; sel1 = vt[i].sel;
            sb_push($sformatf("mux1_vec%0d", i), 32'(vt[i].exp));
            #10;
            sb_pop(32'(out1));
        end

        // Clocking during reset must not disturb the registers
        a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0; en1 = 1'b1;
        a8 = 8'h5A; b8 = 8'hC3; sel8 = 1'b1; en8 = 1'b1;
        clk_en = 1'b1;
        repeat (3) step();
        sb_push("rstclk_out1", 1); sb_pop(32'(out1));
        sb_push("rstclk_q1", 0);   sb_pop(32'(q1));
        sb_push("rstclk_cnt1", 0); sb_pop(32'(cnt1));
        sb_push("rstclk_q8", 0);   sb_pop(32'(q8));
        sb_push("rstclk_cnt8", 0); sb_pop(32'(cnt8));
        sb_push("rstclk_out8", 32'h C3); sb_pop(32'(out8));

        en8 = 1'b0; en1 = 1'b0; sel1 = 1'b0;
        rst_n = 1'b1;

        // Counter: toggle from sel=1 for 5 edges, then hold 3 edges
        for (int i = 0; i < 5; i++) begin
            sel8 = (i % 2 == 0);
            sb_push($sformatf("cnt8_toggle%0d", i), 32'(i + 1));
            step();
            sb_pop(32'(cnt8));
        end
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("cnt8_hold%0d", i), 5);
            step();
            sb_pop(32'(cnt8));
        end
        sb_push("q8_en0_hold", 0); sb_pop(32'(q8));

        // Saturation with CNT_W = 2
        for (int i = 0; i < 6; i++) begin
            sel1 = (i % 2 == 0);
            sb_push($sformatf("cnt1_sat%0d", i), (i < 3) ? 32'(i + 1) : 32'd3);
            step();
            sb_pop(32'(cnt1));
        end
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("cnt1_stay%0d", i), 3);
            step();
            sb_pop(32'(cnt1));
        end

        // Reset pulse between edges
        rst_n = 1'b0;
        #1;
        sb_push("pulse_cnt8", 0); sb_pop(32'(cnt8));
        sb_push("pulse_cnt1", 0); sb_pop(32'(cnt1));
        sel8 = 1'b0;
        step();
        rst_n = 1'b1;

        // Registered path plus build-up to sel_changes = 4
        a8 = 8'h5A; b8 = 8'hC3; en8 = 1'b1; sel8 = 1'b1;
        sb_push("reg_load_q8", 32'h C3); sb_push("reg_load_cnt8", 1);
        step();
        sb_pop(32'(q8)); sb_pop(32'(cnt8));

        en8 = 1'b0; sel8 = 1'b0;
        sb_push("reg_hold_q8", 32'h C3); sb_push("reg_hold_out8", 32'h 5A);
        sb_push("reg_hold_cnt8", 2);
        step();
        sb_pop(32'(q8)); sb_pop(32'(out8)); sb_pop(32'(cnt8));

        sel8 = 1'b1;
        sb_push("build_cnt3", 3);
        step();
        sb_pop(32'(cnt8));
        sel8 = 1'b0;
        sb_push("build_cnt4", 4); sb_push("build_q8", 32'h C3);
        step();
        sb_pop(32'(cnt8)); sb_pop(32'(q8));

        // Mid-operation reset clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("midrst_q8", 0);   sb_pop(32'(q8));
        sb_push("midrst_cnt8", 0); sb_pop(32'(cnt8));
        sb_push("midrst_out8", 32'h 5A); sb_pop(32'(out8));

        // First edge after release is a normal edge; sel=1 counts once
        sel8 = 1'b1; en8 = 1'b1;
        rst_n = 1'b1;
        sb_push("post_rst_q8", 32'h C3); sb_push("post_rst_cnt8", 1);
        step();
        sb_pop(32'(q8)); sb_pop(32'(cnt8));

        n_chk++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL sb_leftover: got %0d pending expected 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
